rom_access_arbiter: RTL and testbench
=====================================

Name: rom_access_arbiter

Overview:
- Sequences all reads of the instruction ROM (512-entry, byte-indexed, word-aligned, tristate `d_out`) for the multi-cycle MIPS32.
- Shares the ROM between two requesters: CPU instruction fetch (port 0) and debug/monitor read (port 1).
- Generates `rom_nce`, `rom_re` and `rom_addr` with a configurable wait-state count.
- Registers the returned word and reports misaligned or out-of-range accesses as errors.

Parameters:
- WAIT_CYCLES, 1, extra ACCESS cycles before ROM data is sampled (0..15).
- ROM_BYTES, 512, size of the ROM byte address space; addresses >= ROM_BYTES are errors.

Ports:
- clk  in  1  system clock, rising edge.
- nrst  in  1  reset, synchronous, active-low.
- cpu_req  in  1  CPU fetch request; held until cpu_ack.
- cpu_addr  in  32  CPU byte address; stable while cpu_req=1.
- cpu_ack  out  1  one-cycle response strobe to CPU.
- cpu_rdata  out  32  fetched word; valid when cpu_ack=1.
- cpu_err  out  1  error flag; valid when cpu_ack=1.
- dbg_req  in  1  debug read request; held until dbg_ack.
- dbg_addr  in  32  debug byte address.
- dbg_ack  out  1  one-cycle response strobe to debug.
- dbg_rdata  out  32  read word.
- dbg_err  out  1  error flag.
- rom_nce  out  1  ROM chip enable, active-low.
- rom_re  out  1  ROM read enable.
- rom_addr  out  9  ROM address = granted addr[8:0].
- rom_data  in  32  ROM data bus; valid only while rom_nce=0 and rom_re=1.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- All outputs are registered.
- Reset (nrst=0 at a clock edge), applied even mid-access:
  - state=IDLE, rom_nce=1, rom_re=0, rom_addr=0.
  - All acks, errs and rdata = 0; busy=0.
  - last_grant=DBG, so the CPU wins the first contention.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requesting: grant the port not equal to last_grant (round-robin); update last_grant on every grant.
  - On grant, latch the address and evaluate the error condition: addr[1:0]!=0 or addr>=ROM_BYTES.
  - Error: go to RESP with err=1 and rdata=0; no ROM cycle, rom_nce stays 1.
  - Otherwise: go to ACCESS; rom_nce=0, rom_re=1, rom_addr=addr[8:0]; wait counter=0.
- ACCESS:
  - rom_nce, rom_re and rom_addr are held.
  - Counter increments each cycle.
  - When counter==WAIT_CYCLES: capture rom_data into the granted port's rdata, set rom_nce=1 and rom_re=0, go to RESP.
  - ROM is enabled for exactly WAIT_CYCLES+1 cycles.
- RESP:
  - Granted port's ack=1 for exactly one cycle, with err; then go to IDLE.
  - rdata/err hold their value until that port's next ack.
  - Non-granted port's ack stays 0.
- Latency, request sampled at edge N:
  - Valid access: ack high in the cycle following edge N+WAIT_CYCLES+2.
  - Error: ack in the cycle following edge N+1.
- Back-to-back: at least one IDLE cycle between transactions. With continuous contention, ports alternate strictly.
- Request dropped before ack (protocol violation): the current access completes; the ack is still pulsed for one cycle. The requester ignores it; there is no abort path.
- A new request from the same port is not sampled in the RESP cycle; it is sampled from IDLE only.
- rom_addr keeps its last value in IDLE (don't-care while rom_nce=1).
- rom_data is never sampled outside ACCESS.

Test Plan:
- Basic fetch, WAIT_CYCLES=1: cpu_req, cpu_addr=0x00000000 -> rom_nce low for 2 cycles with rom_addr=0x000; cpu_ack in cycle 3 after request; cpu_rdata=0x20010008 (addi r1,r0,8); cpu_err=0.
- Errors:
  - cpu_addr=0x00000006 -> cpu_ack one cycle after sampling, cpu_err=1, cpu_rdata=0, rom_nce stays 1.
  - dbg_addr=0x00000200 -> dbg_err=1, same timing.
- Contention: cpu_req and dbg_req both asserted from reset, addrs 0x04/0x08, re-asserted after each ack -> grant order CPU, DBG, CPU, DBG; each ack carries its own port's word; no ack on the other port.
- Wait states: WAIT_CYCLES=0 and 3 with addr 0x0C -> rom_nce low for 1 and 4 cycles respectively; ack latency 2 and 5 cycles; data correct.
- Reset mid-access: assert nrst=0 during the second ACCESS cycle -> next edge gives rom_nce=1, rom_re=0, busy=0, no ack; after release the CPU request is serviced fresh with correct data.
- Dropped request: deassert cpu_req during ACCESS -> access runs to completion, cpu_ack pulses once, controller returns to IDLE, pending dbg_req is then granted.

Source files
------------

// File: rtl/rom_access_arbiter.sv
// rom_access_arbiter
// Sequences every read of the 512-byte instruction ROM for the multi-cycle
// MIPS32. Two requesters share the ROM: CPU instruction fetch (port 0) and
// the debug/monitor read port (port 1). Contention is resolved round-robin.
// A configurable number of wait states is inserted before the ROM data bus
// is sampled. Misaligned or out-of-range addresses are answered with an
// error response and never reach the ROM.
//
// Handshake (both ports): the requester raises req with a stable addr and
// holds both until it sees ack. ack is a single-cycle strobe; rdata and err
// are valid while ack=1 and hold until that port's next ack. A request is
// only sampled while the controller is IDLE. The ack cycle itself is an IDLE
// cycle, so a requester that drops req during its ack cycle is not granted
// again, while the other port's pending request is granted at the end of
// that cycle. A request withdrawn early still completes and is still acked.

module rom_access_arbiter #(
   parameter int WAIT_CYCLES = 1,
   parameter int ROM_BYTES   = 512
) (
   input  logic        clk,
   input  logic        nrst,
   // CPU instruction fetch port
   input  logic        cpu_req,
   input  logic [31:0] cpu_addr,
   output logic        cpu_ack,
   output logic [31:0] cpu_rdata,
   output logic        cpu_err,
   // debug / monitor read port
   input  logic        dbg_req,
   input  logic [31:0] dbg_addr,
   output logic        dbg_ack,
   output logic [31:0] dbg_rdata,
   output logic        dbg_err,
   // ROM interface
   output logic        rom_nce,
   output logic        rom_re,
   output logic [8:0]  rom_addr,
   input  logic [31:0] rom_data,
   // status
   output logic        busy,
   output logic [1:0]  fsm_state
);

   // controller states
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   // port identifiers, also used for last_grant
   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DBG = 1'b1;

   // last ACCESS cycle index and first illegal byte address
   localparam logic [3:0]  WAIT_LAST  = 4'(WAIT_CYCLES);
   localparam logic [31:0] ADDR_LIMIT = 32'(ROM_BYTES);

   logic [1:0]  state;
   logic [1:0]  next_state;
   logic        last_grant;
   logic        cur_port;
   logic        cur_err;
   logic [31:0] cur_word;
   logic [3:0]  wait_cnt;

   logic        grant_valid;
   logic        grant_port;
   logic [31:0] grant_addr;
   logic        grant_err;
   logic        access_done;

   // Arbitration and address check for a grant taken from IDLE this cycle
   always_comb begin
      grant_valid = 1'b0;
      grant_port  = PORT_CPU;
      grant_addr  = cpu_addr;
      grant_err   = 1'b0;
      if (state == ST_IDLE) begin
         grant_valid = cpu_req | dbg_req;
      end
      if (cpu_req && dbg_req) begin
         // round-robin: the port that did not win last time goes first
         grant_port = (last_grant == PORT_DBG) ? PORT_CPU : PORT_DBG;
      end else if (dbg_req) begin
         grant_port = PORT_DBG;
      end else begin
         grant_port = PORT_CPU;
      end
      grant_addr = (grant_port == PORT_DBG) ? dbg_addr : cpu_addr;
      grant_err  = (grant_addr[1:0] != 2'b00) || (grant_addr >= ADDR_LIMIT);
   end

   // The ROM cycle ends once the wait counter reaches the configured count
   always_comb begin
      access_done = (wait_cnt == WAIT_LAST);
   end

   // Next-state selection
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (grant_valid) begin
               next_state = grant_err ? ST_RESP : ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (access_done) begin
               next_state = ST_RESP;
            end
         end
         ST_RESP: begin
            next_state = ST_IDLE;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // State register; busy is registered alongside it from the next state
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state <= ST_IDLE;
         busy  <= 1'b0;
      end else begin
         state <= next_state;
         busy  <= (next_state != ST_IDLE);
      end
   end

   assign fsm_state = state;

   // Grant bookkeeping: who owns the current transaction and its error status
   always_ff @(posedge clk) begin
      if (!nrst) begin
         last_grant <= PORT_DBG;
         cur_port   <= PORT_CPU;
         cur_err    <= 1'b0;
      end else if (grant_valid) begin
         last_grant <= grant_port;
         cur_port   <= grant_port;
         cur_err    <= grant_err;
      end
   end

   // Wait-state counter, cleared on grant and advanced through ACCESS
   always_ff @(posedge clk) begin
      if (!nrst) begin
         wait_cnt <= 4'd0;
      end else if (grant_valid) begin
         wait_cnt <= 4'd0;
      end else if ((state == ST_ACCESS) && !access_done) begin
         wait_cnt <= wait_cnt + 4'd1;
      end
   end

   // ROM strobes: enabled from a legal grant until the data is captured
   always_ff @(posedge clk) begin
      if (!nrst) begin
         rom_nce  <= 1'b1;
         rom_re   <= 1'b0;
         rom_addr <= 9'd0;
      end else if (grant_valid && !grant_err) begin
         rom_nce  <= 1'b0;
         rom_re   <= 1'b1;
         rom_addr <= grant_addr[8:0];
      end else if ((state == ST_ACCESS) && access_done) begin
         rom_nce  <= 1'b1;
         rom_re   <= 1'b0;
      end
   end

   // Captured word: ROM data on the last ACCESS cycle, zero for an error
   always_ff @(posedge clk) begin
      if (!nrst) begin
         cur_word <= 32'd0;
      end else if (grant_valid && grant_err) begin
         cur_word <= 32'd0;
      end else if ((state == ST_ACCESS) && access_done) begin
         cur_word <= rom_data;
      end
   end

   // Response registers: one-cycle ack to the owning port, data/err held
   always_ff @(posedge clk) begin
      if (!nrst) begin
         cpu_ack   <= 1'b0;
         cpu_rdata <= 32'd0;
         cpu_err   <= 1'b0;
         dbg_ack   <= 1'b0;
         dbg_rdata <= 32'd0;
         dbg_err   <= 1'b0;
      end else begin
         cpu_ack <= 1'b0;
         dbg_ack <= 1'b0;
         if (state == ST_RESP) begin
            if (cur_port == PORT_CPU) begin
               cpu_ack   <= 1'b1;
               cpu_rdata <= cur_word;
               cpu_err   <= cur_err;
            end else begin
               dbg_ack   <= 1'b1;
               dbg_rdata <= cur_word;
               dbg_err   <= cur_err;
            end
         end
      end
   end

endmodule

// File: tb/tb_rom_access_arbiter.sv
// tb_rom_access_arbiter
// Directed scenarios followed by randomized traffic on the WAIT_CYCLES=1
// arbiter, compared cycle by cycle against a transaction-level timing model.
// Two extra instances (WAIT_CYCLES=0 and 3) check wait-state timing.

module tb_rom_access_arbiter;

   localparam int WAIT      = 1;
   localparam int ROM_BYTES = 512;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic nrst;
   always #5 clk = ~clk;

   // ---------------- main DUT signals ----------------
   logic        cpu_req, dbg_req;
   logic [31:0] cpu_addr, dbg_addr;
   logic        cpu_ack, dbg_ack, cpu_err, dbg_err;
   logic [31:0] cpu_rdata, dbg_rdata;
   logic        rom_nce, rom_re, busy;
   logic [8:0]  rom_addr;
   logic [31:0] rom_data;
   logic [1:0]  fsm_state;

   logic [31:0] rom_mem [0:127];

   // ROM model: drives the bus only while enabled, garbage otherwise
   assign rom_data = (!rom_nce && rom_re) ? rom_mem[rom_addr[8:2]] : 32'hDEAD_BEEF;

   rom_access_arbiter #(.WAIT_CYCLES(WAIT), .ROM_BYTES(ROM_BYTES)) u_dut (
      .clk(clk), .nrst(nrst),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack),
      .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
      .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack),
      .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
      .rom_nce(rom_nce), .rom_re(rom_re), .rom_addr(rom_addr),
      .rom_data(rom_data), .busy(busy), .fsm_state(fsm_state)
   );

   // ---------------- wait-state instances ----------------
   logic        w0_req, w3_req, ex_dbg_req;
   logic [31:0] ex_addr, ex_dbg_addr;
   logic        w0_ack, w0_err, w0_dack, w0_derr, w0_nce, w0_re, w0_busy;
   logic        w3_ack, w3_err, w3_dack, w3_derr, w3_nce, w3_re, w3_busy;
   logic [31:0] w0_rdata, w0_drdata, w0_rom_data, w3_rdata, w3_drdata, w3_rom_data;
   logic [8:0]  w0_rom_addr, w3_rom_addr;
   logic [1:0]  w0_state, w3_state;

   assign w0_rom_data = (!w0_nce && w0_re) ? rom_mem[w0_rom_addr[8:2]] : 32'hDEAD_BEEF;
   assign w3_rom_data = (!w3_nce && w3_re) ? rom_mem[w3_rom_addr[8:2]] : 32'hDEAD_BEEF;

   rom_access_arbiter #(.WAIT_CYCLES(0), .ROM_BYTES(ROM_BYTES)) u_w0 (
      .clk(clk), .nrst(nrst),
      .cpu_req(w0_req), .cpu_addr(ex_addr), .cpu_ack(w0_ack),
      .cpu_rdata(w0_rdata), .cpu_err(w0_err),
      .dbg_req(ex_dbg_req), .dbg_addr(ex_dbg_addr), .dbg_ack(w0_dack),
      .dbg_rdata(w0_drdata), .dbg_err(w0_derr),
      .rom_nce(w0_nce), .rom_re(w0_re), .rom_addr(w0_rom_addr),
      .rom_data(w0_rom_data), .busy(w0_busy), .fsm_state(w0_state)
   );

   rom_access_arbiter #(.WAIT_CYCLES(3), .ROM_BYTES(ROM_BYTES)) u_w3 (
      .clk(clk), .nrst(nrst),
      .cpu_req(w3_req), .cpu_addr(ex_addr), .cpu_ack(w3_ack),
      .cpu_rdata(w3_rdata), .cpu_err(w3_err),
      .dbg_req(ex_dbg_req), .dbg_addr(ex_dbg_addr), .dbg_ack(w3_dack),
      .dbg_rdata(w3_drdata), .dbg_err(w3_derr),
      .rom_nce(w3_nce), .rom_re(w3_re), .rom_addr(w3_rom_addr),
      .rom_data(w3_rom_data), .busy(w3_busy), .fsm_state(w3_state)
   );

   // ---------------- scoreboard counters ----------------
   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   // A grant at clock edge c owns the controller until its ack cycle:
   // ack in cycle c+1 for an error, c+WAIT+2 otherwise; the ROM is enabled
   // in cycles c..c+WAIT for a legal address.
   bit          m_busy = 1'b0;
   bit          m_err  = 1'b0;
   int          m_port = 0;
   int          m_last = 1;
   int          m_grant = 0;
   int          m_done  = 0;
   logic [31:0] m_word;
   logic [8:0]  m_rom_addr;
   logic [31:0] m_rdata [2];
   logic        m_errh  [2];
   logic        m_ack   [2];
   logic        exp_nce;
   logic        exp_busy;

   task automatic predict(input int c);
      bit          can_grant;
      int          p;
      logic [31:0] a;
      m_ack[0] = 1'b0;
      m_ack[1] = 1'b0;
      if (!nrst) begin
         m_busy = 1'b0; m_last = 1; m_rom_addr = '0;
         m_rdata[0] = '0; m_rdata[1] = '0; m_errh[0] = 1'b0; m_errh[1] = 1'b0;
      end else begin
         can_grant = !m_busy;
         if (m_busy && c == m_done) begin
            m_ack[m_port]   = 1'b1;
            m_rdata[m_port] = m_word;
            m_errh[m_port]  = m_err;
            m_busy          = 1'b0;
         end
         if (can_grant && (cpu_req || dbg_req)) begin
            if (cpu_req && dbg_req) p = (m_last == 0) ? 1 : 0;
            else                    p = cpu_req ? 0 : 1;
            a       = (p == 0) ? cpu_addr : dbg_addr;
            m_last  = p;
            m_port  = p;
            m_err   = (a % 4 != 0) || (a >= ROM_BYTES);
            m_grant = c;
            m_done  = m_err ? c + 1 : c + WAIT + 2;
            m_word  = m_err ? 32'd0 : rom_mem[a[8:2]];
            if (!m_err) m_rom_addr = a[8:0];
            m_busy  = 1'b1;
         end
      end
      exp_nce  = !(m_busy && !m_err && c >= m_grant && c <= m_grant + WAIT);
      exp_busy = m_busy;
   endtask

   // One clock: predict the coming cycle from the current inputs, then
   // compare every main-DUT output away from the active edge
   task automatic tick();
      predict(cyc + 1);
      @(negedge clk);
      cyc++;
      check_eq("cpu_ack",   cpu_ack,   m_ack[0]);
      check_eq("dbg_ack",   dbg_ack,   m_ack[1]);
      check_eq("cpu_rdata", cpu_rdata, m_rdata[0]);
      check_eq("dbg_rdata", dbg_rdata, m_rdata[1]);
      check_eq("cpu_err",   cpu_err,   m_errh[0]);
      check_eq("dbg_err",   dbg_err,   m_errh[1]);
      check_eq("rom_nce",   rom_nce,   exp_nce);
      check_eq("rom_re",    rom_re,    !exp_nce);
      check_eq("rom_addr",  rom_addr,  m_rom_addr);
      check_eq("busy",      busy,      exp_busy);
   endtask

   // ---------------- driver tasks ----------------
   task automatic wait_ack(input int p, input int limit, output int lat, output int nce_lo);
      bit seen;
      seen   = 1'b0;
      lat    = -1;
      nce_lo = 0;
      for (int k = 1; k <= limit && !seen; k++) begin
         tick();
         if (!rom_nce) nce_lo++;
         if ((p == 0 && cpu_ack) || (p == 1 && dbg_ack)) begin
            seen = 1'b1;
            lat  = k - 1;
            if (p == 0) cpu_req = 1'b0;
            else        dbg_req = 1'b0;
         end
      end
      check_eq("ack_seen", seen, 1'b1);
   endtask

   function automatic logic [31:0] gen_addr();
      int          r;
      logic [31:0] a;
      r = $urandom_range(0, 99);
      a = 32'($urandom_range(0, 127)) << 2;
      if (r < 5)       a = 32'd508;
      else if (r < 10) a = 32'd512;
      else if (r < 18) a = a | 32'($urandom_range(1, 3));
      else if (r < 24) a = $urandom();
      return a;
   endfunction

   task automatic rand_drive();
      if (cpu_ack)                             cpu_req = 1'b0;
      else if (!cpu_req && $urandom_range(0, 99) < 40) begin cpu_req = 1'b1; cpu_addr = gen_addr(); end
      else if (cpu_req && $urandom_range(0, 99) < 3)   cpu_req = 1'b0;
      if (dbg_ack)                             dbg_req = 1'b0;
      else if (!dbg_req && $urandom_range(0, 99) < 40) begin dbg_req = 1'b1; dbg_addr = gen_addr(); end
      else if (dbg_req && $urandom_range(0, 99) < 3)   dbg_req = 1'b0;
      nrst = ($urandom_range(0, 299) != 0);
   endtask

   // ---------------- main sequence ----------------
   logic [1:0] exp_q [$];
   int lat, nce_lo;
   int lat0, lat3, n0, n3;
   logic [31:0] d0, d3;
   logic e0, e3;
   bit rearm_c, rearm_d;

   initial begin
      for (int i = 0; i < 128; i++) rom_mem[i] = $urandom();
      rom_mem[0] = 32'h2001_0008;
      nrst = 1'b0;
      cpu_req = 1'b0; dbg_req = 1'b0; cpu_addr = '0; dbg_addr = '0;
      w0_req = 1'b0; w3_req = 1'b0; ex_addr = 32'h0000_000C;
      ex_dbg_req = 1'b0; ex_dbg_addr = '0;

      repeat (3) tick();
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_nce", rom_nce, 1'b1);
      nrst = 1'b1;
      repeat (2) tick();

      // basic fetch of address 0
      cpu_req = 1'b1; cpu_addr = 32'h0;
      wait_ack(0, 20, lat, nce_lo);
      check_eq("fetch_lat", lat, WAIT + 2);
      check_eq("fetch_nce_cycles", nce_lo, WAIT + 1);
      check_eq("fetch_rdata", cpu_rdata, 32'h2001_0008);
      check_eq("fetch_err", cpu_err, 1'b0);
      tick();

      // misaligned CPU address
      cpu_req = 1'b1; cpu_addr = 32'h6;
      wait_ack(0, 20, lat, nce_lo);
      check_eq("mis_lat", lat, 1);
      check_eq("mis_nce_cycles", nce_lo, 0);
      check_eq("mis_err", cpu_err, 1'b1);
      check_eq("mis_rdata", cpu_rdata, 32'h0);
      tick();

      // out-of-range debug address
      dbg_req = 1'b1; dbg_addr = 32'h200;
      wait_ack(1, 20, lat, nce_lo);
      check_eq("oor_lat", lat, 1);
      check_eq("oor_nce_cycles", nce_lo, 0);
      check_eq("oor_err", dbg_err, 1'b1);
      check_eq("oor_rdata", dbg_rdata, 32'h0);
      tick();

      // contention from reset, both ports re-requesting after each ack
      nrst = 1'b0;
      cpu_req = 1'b1; cpu_addr = 32'h4; dbg_req = 1'b1; dbg_addr = 32'h8;
      tick();
      nrst = 1'b1;
      exp_q.push_back(2'd0); exp_q.push_back(2'd1);
      exp_q.push_back(2'd0); exp_q.push_back(2'd1);
      rearm_c = 1'b0; rearm_d = 1'b0;
      for (int k = 0; k < 60 && exp_q.size() != 0; k++) begin
         tick();
         if (cpu_ack && exp_q.size() != 0) begin
            check_eq("cont_order", 2'd0, exp_q.pop_front());
            check_eq("cont_cpu_word", cpu_rdata, rom_mem[1]);
            cpu_req = 1'b0; rearm_c = 1'b1;
         end else if (rearm_c) begin
            cpu_req = 1'b1; rearm_c = 1'b0;
         end
         if (dbg_ack && exp_q.size() != 0) begin
            check_eq("cont_order", 2'd1, exp_q.pop_front());
            check_eq("cont_dbg_word", dbg_rdata, rom_mem[2]);
            dbg_req = 1'b0; rearm_d = 1'b1;
         end else if (rearm_d) begin
            dbg_req = 1'b1; rearm_d = 1'b0;
         end
      end
      check_eq("cont_left", exp_q.size(), 0);
      cpu_req = 1'b0; dbg_req = 1'b0;
      repeat (8) tick();

      // reset during the second ACCESS cycle
      cpu_req = 1'b1; cpu_addr = 32'h10;
      tick();
      tick();
      nrst = 1'b0;
      tick();
      check_eq("rmid_busy", busy, 1'b0);
      check_eq("rmid_nce", rom_nce, 1'b1);
      check_eq("rmid_re", rom_re, 1'b0);
      check_eq("rmid_ack", cpu_ack, 1'b0);
      nrst = 1'b1;
      wait_ack(0, 20, lat, nce_lo);
      check_eq("rmid_lat", lat, WAIT + 2);
      check_eq("rmid_rdata", cpu_rdata, rom_mem[4]);
      tick();

      // CPU drops its request mid-access while debug waits
      cpu_req = 1'b1; cpu_addr = 32'h14;
      tick();
      dbg_req = 1'b1; dbg_addr = 32'h18;
      tick();
      cpu_req = 1'b0;
      wait_ack(0, 20, lat, nce_lo);
      check_eq("drop_cpu_rdata", cpu_rdata, rom_mem[5]);
      wait_ack(1, 20, lat, nce_lo);
      check_eq("drop_dbg_lat", lat, WAIT + 2);
      check_eq("drop_dbg_rdata", dbg_rdata, rom_mem[6]);
      check_eq("drop_cpu_hold", cpu_rdata, rom_mem[5]);
      tick();

      // randomized traffic with occasional resets
      for (int k = 0; k < 2000; k++) begin
         rand_drive();
         tick();
      end
      nrst = 1'b1; cpu_req = 1'b0; dbg_req = 1'b0;
      repeat (10) tick();
      check_eq("drain_busy", busy, 1'b0);

      // wait-state timing at WAIT_CYCLES 0 and 3, address 0x0C
      lat0 = -1; lat3 = -1; n0 = 0; n3 = 0; d0 = '0; d3 = '0; e0 = 1'b1; e3 = 1'b1;
      w0_req = 1'b1; w3_req = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (!w0_nce) n0++;
         if (!w3_nce) n3++;
         if (w0_ack && lat0 < 0) begin lat0 = k - 1; d0 = w0_rdata; e0 = w0_err; w0_req = 1'b0; end
         if (w3_ack && lat3 < 0) begin lat3 = k - 1; d3 = w3_rdata; e3 = w3_err; w3_req = 1'b0; end
      end
      check_eq("w0_lat", lat0, 2);
      check_eq("w0_nce_cycles", n0, 1);
      check_eq("w0_rdata", d0, rom_mem[3]);
      check_eq("w0_err", e0, 1'b0);
      check_eq("w3_lat", lat3, 5);
      check_eq("w3_nce_cycles", n3, 4);
      check_eq("w3_rdata", d3, rom_mem[3]);
      check_eq("w3_err", e3, 1'b0);
      check_eq("w_idle", {w0_busy, w3_busy, w0_dack, w3_dack, w0_derr, w3_derr}, 6'd0);
      check_eq("w_dbg_rdata", w0_drdata | w3_drdata, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // watchdog so the run always terminates
   initial begin
      #1_000_000;
      $display("FAIL watchdog cycle %0d: got timeout expected completion", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
